program_loader: RTL
===================

# program_loader

Byte-stream program loader that sits directly upstream of the two-phase MIPS-32 core. It receives a framed program image over a byte-wide valid/ready link, assembles big-endian 32-bit words and writes them into the core's unified word-addressed Memory. It holds the core stalled until the frame's checksum verifies, then releases the core with the start PC. It replaces hand-poking Memory, PC and HALTED from a bench.

## Interface
Parameters:
- ADDR_W, 10, word-address width of the memory write port (1024 words).

Ports:
- clk1  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  byte present on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; transfer = in_valid & in_ready at the edge.
- load_req  in  1  one-cycle request: abort or restart, return to IDLE.
- mem_we  out  1  one-cycle memory write strobe.
- mem_addr  out  ADDR_W  word address for the write.
- mem_wdata  out  32  word to write.
- cpu_run  out  1  high = core released; low = core held (HALTED forced, PC loaded).
- cpu_pc  out  32  start PC, zero-extended base address; valid while cpu_run is high.
- done  out  1  one-cycle pulse on a successful load.
- err  out  1  sticky checksum-failure flag.

## Operation
- Frame layout: sync 0xA5, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then 4×CNT data bytes (MSB first per word), then CSUM.
- The base address is the low ADDR_W bits of {ADDR_HI,ADDR_LO}. Upper bits are ignored.
- CSUM equals the 8-bit modulo-256 sum of every byte after sync, up to and excluding CSUM.
- States: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, CSUM, RUN, ERR.
- IDLE: discards every byte other than 0xA5. On 0xA5, go to ADDR_HI and clear the running sum.
- Header states advance one state per accepted byte. After CNT_LO, go to DATA if the count is nonzero, else go to CSUM.
- DATA: shift bytes into a word register. On the 4th byte, issue a write and increment the write address modulo 2^ADDR_W (0x3FF wraps to 0x000). After CNT words, go to CSUM.
- CSUM match: go to RUN, pulse done, set cpu_run=1, set cpu_pc = base.
- CSUM mismatch: go to ERR and set err=1. Words already written stay in memory. cpu_run stays 0.
- RUN and ERR: in_ready=0. Only load_req leaves these states. load_req goes to IDLE, clears err, and drops cpu_run.
- load_req in any loading state aborts to IDLE with no further writes.
- load_req in the same cycle as a byte transfer: load_req wins and the byte is dropped.
- Reset values: state=IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, cpu_pc=0, done=0, err=0.
- Reset mid-load: immediate return to IDLE. Words already written are not undone.

## Timing
- in_ready is combinational from state: 1 in IDLE through CSUM, 0 in RUN and ERR. No backpressure while loading, so back-to-back bytes every cycle are supported.
- mem_we, mem_addr and mem_wdata are registered. The write occurs in the cycle after the edge that accepts the 4th byte of a word. Consecutive words can therefore write every 4 cycles at full rate.
- done and cpu_run rise in the cycle after the edge that accepts CSUM. cpu_pc is stable from that cycle on.
- cpu_run falls in the cycle after load_req is sampled.
- The minimum frame (CNT=0) is 6 bytes, so done rises 6 cycles after the first byte at full rate.

## Test plan
- Full-rate stream A5 00 78 00 01 00 00 00 11 8A -> exactly one write: mem_addr=120, mem_wdata=17. Then done pulse, cpu_run=1, cpu_pc=120, err=0.
- Same frame with CSUM=0x8B -> write to 120 still occurs, err=1, cpu_run=0, no done. Then load_req -> err=0, state IDLE.
- Garbage 00 FF 12 before A5 00 05 00 00 05 -> no writes, done, cpu_pc=5.
- Wrap: base 0x03FF, count 2, words 0x0CE77800 and 0xFC000000 -> writes at 0x3FF then 0x000.
- load_req asserted after 6 of 8 data bytes -> only the first word is written, cpu_run=0. A following valid frame loads normally.
- Mid-frame: rst_n=0 for one cycle -> every output returns to its reset value. in_valid with random gaps -> results identical to the full-rate run.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream program loader: parses a framed image, writes big-endian words
// into core memory, and releases the core at the base PC once the checksum matches.
module program_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              load_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic [31:0]       cpu_pc,
  output logic              done,
  output logic              err
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam logic [BYTE_W-1:0] SYNC = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   sum_q, sum_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          bidx_q, bidx_d;
  logic [23:0]         word_q, word_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_run_q, cpu_run_d;
  logic [31:0]         cpu_pc_q, cpu_pc_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                xfer;
  logic [CNT_W-1:0]    cnt_in;

  // Loader never backpressures while a frame is in flight.
  assign in_ready = (state_q != S_RUN) && (state_q != S_ERR);
  assign xfer     = in_valid && in_ready;
  assign cnt_in   = {hi_q, in_data};

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    hi_d        = hi_q;
    base_d      = base_q;
    waddr_d     = waddr_q;
    cnt_d       = cnt_q;
    bidx_d      = bidx_q;
    word_d      = word_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_run_d   = cpu_run_q;
    cpu_pc_d    = cpu_pc_q;
    done_d      = 1'b0;
    err_d       = err_q;

    // load_req outranks any byte presented in the same cycle.
    if (load_req) begin
      state_d   = S_IDLE;
      err_d     = 1'b0;
      cpu_run_d = 1'b0;
    end else if (xfer) begin
      if (state_q != S_IDLE && state_q != S_CSUM) begin
        sum_d = sum_q + in_data;
      end
      case (state_q)
        S_IDLE: begin
          if (in_data == SYNC) begin
            state_d = S_ADDR_HI;
            sum_d   = '0;
          end
        end
        S_ADDR_HI: begin
          hi_d    = in_data;
          state_d = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          base_d  = ADDR_W'({hi_q, in_data});
          waddr_d = ADDR_W'({hi_q, in_data});
          state_d = S_CNT_HI;
        end
        S_CNT_HI: begin
          hi_d    = in_data;
          state_d = S_CNT_LO;
        end
        S_CNT_LO: begin
          cnt_d   = cnt_in;
          bidx_d  = 2'd0;
          state_d = (cnt_in == '0) ? S_CSUM : S_DATA;
        end
        S_DATA: begin
          word_d = {word_q[15:0], in_data};
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = waddr_q;
            mem_wdata_d = {word_q, in_data};
            waddr_d     = waddr_q + ADDR_W'(1);
            cnt_d       = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (in_data == sum_q) begin
            state_d   = S_RUN;
            done_d    = 1'b1;
            cpu_run_d = 1'b1;
            cpu_pc_d  = 32'(base_q);
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      hi_q        <= '0;
      base_q      <= '0;
      waddr_q     <= '0;
      cnt_q       <= '0;
      bidx_q      <= '0;
      word_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_run_q   <= 1'b0;
      cpu_pc_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      hi_q        <= hi_d;
      base_q      <= base_d;
      waddr_q     <= waddr_d;
      cnt_q       <= cnt_d;
      bidx_q      <= bidx_d;
      word_q      <= word_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_run_q   <= cpu_run_d;
      cpu_pc_q    <= cpu_pc_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_run   = cpu_run_q;
  assign cpu_pc    = cpu_pc_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
